even_parity_serial_tx: RTL

//  - Transmit side of the even-parity link: accepts a DATA_W-bit word over a valid/ready handshake.
//  - Computes the even-parity bit and serialises one frame: start(0), data LSB-first, parity, stop(1).
//  - The downstream receiver/checker sees an even total weight over {parity,data}.
//  - Sits between the word source and the single-wire serial line.

---
 rtl/even_parity_pkg.sv | 16 +
 rtl/even_parity_gen.sv | 11 +
 rtl/even_parity_serial_tx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/even_parity_pkg.sv
// Shared types and line-level constants for the even-parity serial link.
package even_parity_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } txState_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/even_parity_gen.sv
// Even-parity generator: XOR reduction of the word, shared by the TX and RX sides.
module even_parity_gen #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] data,
    output logic              parity
);

    assign parity = ^data;

endmodule

// File: rtl/even_parity_serial_tx.sv
// Even-parity serial transmitter: frames a handshaked word as start, LSB-first data, parity, stop.
module even_parity_serial_tx
    import even_parity_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int BIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              parity_out,
    output logic              frame_done
);

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(DATA_W - 1);

    txState_t          state, stateNext;
    logic [CNT_W-1:0]  cycCnt, cycCntNext;
    logic [IDX_W-1:0]  bitIdx, bitIdxNext;
    logic [DATA_W-1:0] shreg, shregNext;
    logic              parityNext;
    logic              txNext;
    logic              busyNext;
    logic              doneNext;
    logic              cycleEnd;
    logic              accept;
    logic              wordParity;

    even_parity_gen #(
        .DATA_W(DATA_W)
    ) uParityGen (
        .data  (in_data),
        .parity(wordParity)
    );

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign cycleEnd = (cycCnt == CYC_LAST);

    always_comb begin
        stateNext  = state;
        cycCntNext = cycCnt;
        bitIdxNext = bitIdx;
        shregNext  = shreg;
        parityNext = parity_out;

        if (state != IDLE) begin
            cycCntNext = cycleEnd ? '0 : cycCnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext  = START;
                    shregNext  = in_data;
                    parityNext = wordParity;
                end
            end
            START: begin
                if (cycleEnd) begin
                    stateNext  = DATA;
                    bitIdxNext = '0;
                end
            end
            DATA: begin
                if (cycleEnd) begin
                    shregNext = shreg >> 1;
                    if (bitIdx == BIT_LAST) begin
                        stateNext = PARITY;
                    end else begin
                        bitIdxNext = bitIdx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (cycleEnd) stateNext = STOP;
            end
            STOP: begin
                if (cycleEnd) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase

        // Outputs are registered, so derive them from where the FSM lands next.
        case (stateNext)
            START:   txNext = START_BIT;
            DATA:    txNext = shregNext[0];
            PARITY:  txNext = parityNext;
            STOP:    txNext = STOP_BIT;
            default: txNext = LINE_IDLE;
        endcase
        busyNext = (stateNext != IDLE);
        doneNext = (stateNext == STOP) && (cycCntNext == CYC_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cycCnt     <= '0;
            bitIdx     <= '0;
            shreg      <= '0;
            parity_out <= 1'b0;
            tx_out     <= LINE_IDLE;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= stateNext;
            cycCnt     <= cycCntNext;
            bitIdx     <= bitIdxNext;
            shreg      <= shregNext;
            parity_out <= parityNext;
            tx_out     <= txNext;
            tx_busy    <= busyNext;
            frame_done <= doneNext;
        end
    end

endmodule
